// File: rtl/prom_read_ctrl.sv
// prom_read_ctrl: SPI (mode 0) read-command engine for a serial configuration
// flash. On start it issues READ (0x03) + 24-bit address, then clocks in
// len+1 bytes, delivering each on data/data_valid, and finishes with a
// chip-select hold, a deselect gap and a one-cycle done pulse.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start, addr, len  request (accepted only in IDLE); len = bytes-1
//   busy              high from the cycle after acceptance to frame end
//   data, data_valid  last received byte and its one-cycle strobe
//   done              one-cycle pulse in the first IDLE cycle after a frame
//   SPICLK, SPIMOSI, SPIMISO, cs_prom_n   flash pins
module prom_read_ctrl #(
  parameter int CLK_DIV   = 2,  // SPICLK half-period in clk cycles (1..255)
  parameter int DESEL_CYC = 5   // cs_prom_n high time after a frame
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        done,
  input  logic        SPIMISO,
  output logic        SPICLK,
  output logic        SPIMOSI,
  output logic        cs_prom_n
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, DATA, CS_HOLD, DESEL} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt;       // cycles within a half-period / deselect gap
  logic [10:0] bit_cnt;   // bits completed in CMD or DATA
  logic [7:0]  len_q;
  logic [30:0] cmd_sr;    // command bits still to be shifted after the current one
  logic [6:0]  rx_sr;
  logic        sclk_q, mosi_q, dv_q, done_q;
  logic [7:0]  data_q;

  logic [31:0] cmd_w;
  logic        half_end, shifting, fall, last_cmd, last_data, desel_end;

  assign cmd_w     = {8'h03, addr};
  assign half_end  = (cnt == 16'(CLK_DIV - 1));
  assign shifting  = (state_q == CMD) || (state_q == DATA);
  // the edge that ends a high half-period: SPICLK falls, MISO is sampled,
  // MOSI advances
  assign fall      = shifting && half_end && sclk_q;
  assign last_cmd  = (bit_cnt[4:0] == 5'd31);
  assign last_data = (bit_cnt == {len_q, 3'b111});
  assign desel_end = (cnt == 16'(DESEL_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)                 state_d = CS_SETUP;
      CS_SETUP: if (half_end)              state_d = CMD;
      CMD:      if (fall && last_cmd)      state_d = DATA;
      DATA:     if (fall && last_data)     state_d = CS_HOLD;
      CS_HOLD:  if (half_end)              state_d = DESEL;
      DESEL:    if (desel_end)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      cmd_sr  <= '0;
      rx_sr   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= (state_q == DESEL) && desel_end;

      if (state_d != state_q || state_q == IDLE || (shifting && half_end))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;

      // SPICLK only runs in CMD/DATA; each phase change ends a half-period
      if (shifting && half_end) sclk_q <= ~sclk_q;
      else if (!shifting)       sclk_q <= 1'b0;

      if (state_d != state_q) bit_cnt <= '0;
      else if (fall)          bit_cnt <= bit_cnt + 11'd1;

      if (state_q == IDLE && start) begin
        len_q  <= len;
        cmd_sr <= cmd_w[30:0];
        mosi_q <= cmd_w[31];
      end

      if (state_q == CMD && fall) begin
        mosi_q <= last_cmd ? 1'b0 : cmd_sr[30];
        cmd_sr <= {cmd_sr[29:0], 1'b0};
      end

      if (state_q == DATA && fall) begin
        rx_sr <= {rx_sr[5:0], SPIMISO};
        if (bit_cnt[2:0] == 3'd7) begin
          data_q <= {rx_sr, SPIMISO};
          dv_q   <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign cs_prom_n  = (state_q == IDLE) || (state_q == DESEL);
  assign SPICLK     = sclk_q;
  assign SPIMOSI    = mosi_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_prom_read_ctrl.sv
// Bench for prom_read_ctrl (CLK_DIV=2, DESEL_CYC=5) with a mode-0 flash model.
module tb_prom_read_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy, data_valid, done;
  logic [7:0]  data;
  logic        SPIMISO = 1'b0;
  logic        SPICLK, SPIMOSI, cs_prom_n;

  always #5 clk = ~clk;

  prom_read_ctrl #(.CLK_DIV(2), .DESEL_CYC(5)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len),
    .busy(busy), .data(data), .data_valid(data_valid), .done(done),
    .SPIMISO(SPIMISO), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .cs_prom_n(cs_prom_n)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flash contents
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h11;
      24'h000011: return 8'h22;
      24'h000012: return 8'h33;
      24'h000013: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // mode-0 flash: sample MOSI on SPICLK rise, drive MISO on SPICLK fall
  int          rcnt = 0, ocnt = 0;
  logic [31:0] cmd_sh = '0;
  logic [7:0]  fb;
  always @(posedge cs_prom_n) begin rcnt = 0; ocnt = 0; end
  always @(posedge SPICLK) if (!cs_prom_n) begin
    if (rcnt < 32) cmd_sh = {cmd_sh[30:0], SPIMOSI};
    rcnt++;
  end
  always @(negedge SPICLK) if (!cs_prom_n && rcnt >= 32) begin
    fb = mem_byte(cmd_sh[23:0] + 24'(ocnt / 8));
    SPIMISO <= fb[7 - (ocnt % 8)];
    ocnt++;
  end

  // monitor, sampled 1 time unit after each rising edge
  int         busy_cyc, rises, dv_cnt, done_cnt, tog_err;
  int         hi_run = 0, last_hi_run = 0;
  logic       sclk_prev = 1'b0;
  logic [7:0] rxq[$];
  always @(posedge clk) begin
    #1;
    if (busy) busy_cyc++;
    if (SPICLK && !sclk_prev) rises++;
    if (cs_prom_n && SPICLK) tog_err++;
    if (data_valid) begin dv_cnt++; rxq.push_back(data); end
    if (done) done_cnt++;
    if (cs_prom_n) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    sclk_prev = SPICLK;
  end

  task automatic clr();
    busy_cyc = 0; rises = 0; dv_cnt = 0; done_cnt = 0; tog_err = 0;
    rxq.delete();
  endtask

  task automatic start_txn(input logic [23:0] a, input logic [7:0] l);
    clr();
    start = 1'b1; addr = a; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_txn(input logic [23:0] a, input int eb, input int er, input int ed);
    int bad = 0;
    chk("busy_cycles", busy_cyc, eb);
    chk("sclk_rises", rises, er);
    chk("dv_pulses", dv_cnt, ed);
    chk("done_pulses", done_cnt, 1);
    chk("mosi_cmd", cmd_sh, {8'h03, a});
    chk("sclk_while_desel", tog_err, 0);
    foreach (rxq[i]) if (rxq[i] !== mem_byte(a + 24'(i))) bad++;
    chk("data_bytes", bad, 0);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [7:0]  l;
    int          eb;   // busy cycles
    int          er;   // SPICLK rising edges
    int          ed;   // data_valid pulses
  } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{24'h000010, 8'd3,   265,  64,  4};
    vt[1] = '{24'h000010, 8'd0,   169,  40,  1};
    vt[2] = '{24'h00ABCD, 8'd1,   201,  48,  2};
    vt[3] = '{24'hFFFFFC, 8'd7,   393,  96,  8};
    vt[4] = '{24'h000200, 8'hFF, 8329, 2080, 256};

    reset = 1'b1; start = 1'b0; addr = '0; len = '0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs_prom_n}, 1);
    chk("rst_sclk", {31'd0, SPICLK}, 0);
    chk("rst_mosi", {31'd0, SPIMOSI}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dv_done", {30'd0, data_valid, done}, 0);
    chk("rst_data", {24'd0, data}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      start_txn(vt[i].a, vt[i].l);
      wait_done(20000);
      repeat (3) @(negedge clk);
      check_txn(vt[i].a, vt[i].eb, vt[i].er, vt[i].ed);
      if (i == 0) begin
        chk("basic_byte0", {24'd0, (rxq.size() > 0) ? rxq[0] : 8'h00}, 8'h11);
        chk("basic_byte3", {24'd0, (rxq.size() > 3) ? rxq[3] : 8'h00}, 8'h44);
      end
    end

    // start mid-frame must be ignored
    start_txn(24'h000010, 8'd3);
    repeat (100) @(negedge clk);
    start = 1'b1; addr = 24'h000100; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);
    repeat (40) @(negedge clk);
    check_txn(24'h000010, 265, 64, 4);
    chk("ignored_busy_idle", {31'd0, busy}, 0);

    // back-to-back: start held in the done cycle
    start_txn(24'h000010, 8'd0);
    wait_done(5000);
    start_txn(24'h00ABCD, 8'd1);
    chk("b2b_cs_low", {31'd0, cs_prom_n}, 0);
    wait_done(5000);
    repeat (3) @(negedge clk);
    check_txn(24'h00ABCD, 201, 48, 2);
    chk("b2b_desel_min", {31'd0, last_hi_run >= 5}, 1);

    // reset in the middle of DATA
    start_txn(24'h000010, 8'd3);
    begin
      int k = 0;
      while (dv_cnt < 2 && k < 5000) begin @(negedge clk); k++; end
    end
    chk("mid_dv_reached", dv_cnt, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", {31'd0, cs_prom_n}, 1);
    chk("mid_rst_sclk", {31'd0, SPICLK}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_data", {24'd0, data}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_idle", {31'd0, busy}, 0);
    start_txn(24'h000011, 8'd1);
    wait_done(5000);
    repeat (3) @(negedge clk);
    check_txn(24'h000011, 201, 48, 2);
    chk("post_rst_byte0", {24'd0, (rxq.size() > 0) ? rxq[0] : 8'h00}, 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
